// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: divider FSM states, iteration count and counter sizing.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = DIV_WIDTH;
    localparam int DIV_CNT_W = $clog2(DIV_ITER);

    // Counter width able to hold 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mdu_divider_if.sv
// Start/busy/done handshake and operand/result bus between control unit and divider.
interface mdu_divider_if #(
    parameter int WIDTH = mips_pkg::DIV_WIDTH
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, sign, dividend, divisor,
        input  busy, done, dz, quotient, remainder
    );

    modport slave (
        input  start, sign, dividend, divisor,
        output busy, done, dz, quotient, remainder
    );
endinterface

// File: rtl/mdu_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, select.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quotient_bit
);
    logic [WIDTH:0] partial;
    logic [WIDTH:0] trial;

    // rem < divisor always holds, so the shifted partial fits in WIDTH+1 bits.
    assign partial      = {rem, dividend_bit};
    assign trial        = partial - {1'b0, divisor};
    assign quotient_bit = ~trial[WIDTH];
    assign rem_next     = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
endmodule

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider for MIPS div/divu, fixed WIDTH+1 cycle latency.
// Signed (div) support is built only when MDU_DIV_SIGNED_EN is defined.
module mdu_divider
    import mips_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mdu_divider_if.slave  bus
);
    localparam int                CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg, raw_reg;
    logic             dz_pend_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             done_reg, dz_reg;

    logic [WIDTH-1:0] dvd_mag, dvs_mag, q_fin, r_fin, step_rem;
    logic             step_bit, accept, calc, fin, busy;

    // ---------------- FSM: state register / next state / outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (cnt_reg == LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        calc   = 1'b0;
        fin    = 1'b0;
        busy   = 1'b0;
        case (state_reg)
            IDLE:    accept = bus.start;
            CALC:    begin calc = 1'b1; busy = 1'b1; end
            FIN:     begin fin  = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    // ---------------- Sign handling ----------------
`ifdef MDU_DIV_SIGNED_EN
    logic neg_q_reg, neg_r_reg;
    logic dvd_neg, dvs_neg;

    assign dvd_neg = bus.sign & bus.dividend[WIDTH-1];
    assign dvs_neg = bus.sign & bus.divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
    assign dvs_mag = dvs_neg ? -bus.divisor  : bus.divisor;
    // Negating 0x80..0 wraps back to itself, which yields the no-trap overflow result.
    assign q_fin   = neg_q_reg ? -quo_reg : quo_reg;
    assign r_fin   = neg_r_reg ? -rem_reg : rem_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (accept) begin
            neg_q_reg <= dvd_neg ^ dvs_neg;
            neg_r_reg <= dvd_neg;
        end
    end
`else
    logic sign_unused;

    assign sign_unused = bus.sign;
    assign dvd_mag     = bus.dividend;
    assign dvs_mag     = bus.divisor;
    assign q_fin       = quo_reg;
    assign r_fin       = rem_reg;
`endif

    // ---------------- Datapath ----------------
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem_reg),
        .dividend_bit (quo_reg[WIDTH-1]),
        .divisor      (dvs_reg),
        .rem_next     (step_rem),
        .quotient_bit (step_bit)
    );

    // quo_reg starts as the dividend and is shifted out MSB-first while quotient bits enter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            raw_reg       <= '0;
            dz_pend_reg   <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            done_reg      <= 1'b0;
            dz_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                cnt_reg     <= '0;
                rem_reg     <= '0;
                quo_reg     <= dvd_mag;
                dvs_reg     <= dvs_mag;
                raw_reg     <= bus.dividend;
                dz_pend_reg <= (bus.divisor == '0);
            end else if (calc) begin
                cnt_reg <= cnt_reg + 1'b1;
                rem_reg <= step_rem;
                quo_reg <= {quo_reg[WIDTH-2:0], step_bit};
            end else if (fin) begin
                done_reg      <= 1'b1;
                dz_reg        <= dz_pend_reg;
                quotient_reg  <= dz_pend_reg ? '1 : q_fin;
                remainder_reg <= dz_pend_reg ? raw_reg : r_fin;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done_reg;
    assign bus.dz        = dz_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
endmodule

// File: doc/mdu_divider.md
# mdu_divider

Multi-cycle 32-bit integer divider for the MIPS `div`/`divu` path. It sits directly downstream of the register file and consumes the `rs_data` and `rt_data` operand pair. It produces quotient (LO) and remainder (HI) for the HI/LO write stage. It uses a radix-2 restoring algorithm: one quotient bit per cycle, a fixed latency, and a start/busy/done handshake toward the control unit.

## Interface
- `WIDTH`, default 32: operand and result width. The iteration count equals `WIDTH`.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request. Sampled only in IDLE.
- `sign` in 1: 1 selects `div` (signed), 0 selects `divu` (unsigned).
- `dividend` in WIDTH: operand from `rs_data`. Sampled on the accepting edge.
- `divisor` in WIDTH: operand from `rt_data`. Sampled on the accepting edge.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: single-cycle pulse; results valid from this cycle on.
- `dz` out 1: divide-by-zero flag for the last operation.
- `quotient` out WIDTH: goes to LO.
- `remainder` out WIDTH: goes to HI.

## Operation
- States: IDLE → CALC → FIN → IDLE.
- **IDLE**
  - When `start`=1, latch the operands into working registers and go to CALC with iteration counter = 0.
  - In signed mode, latch the magnitudes, and record `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend).
- **CALC**, one iteration per cycle:
  - Shift partial remainder left by one, bringing in the next dividend MSB.
  - Compute trial = partial − divisor using a WIDTH+1-bit subtract.
  - If trial is non-negative, keep it and shift quotient bit 1; otherwise keep the partial remainder and shift 0.
  - The counter increments each cycle. After the iteration with counter = WIDTH−1, go to FIN.
- **FIN**
  - Apply sign correction: two's-complement negate the quotient if `neg_q`, and the remainder if `neg_r`.
  - Register `quotient`, `remainder` and `dz`, pulse `done`, and return to IDLE.
- Result rules:
  - Quotient truncates toward zero; the remainder's sign follows the dividend.
  - 0x80000000 / −1 (signed) gives quotient 0x80000000, remainder 0. This is natural wrap with no trap.
- Divide by zero:
  - Flagged in IDLE when `divisor`=0. `dz`=1 in FIN.
  - Forced results, for both signed and unsigned: `quotient`=all ones, `remainder`=raw dividend.
  - Latency is unchanged.
- Outputs hold their values until the next FIN. Operand inputs are ignored outside the accepting edge.
- `start` while `busy`=1 is ignored and is not queued.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `dz`=0, `quotient`=0, `remainder`=0, counter 0.
- With `start` accepted at edge k:
  - `busy` is 1 from after edge k through edge k+WIDTH+1.
  - CALC edges are k+1 … k+WIDTH.
  - FIN edge is k+WIDTH+1: `done`=1 and `busy`=0 for one cycle. For WIDTH=32 this is 33 cycles.
- Back-to-back: `start` held high in the `done` cycle is accepted at that cycle's ending edge, with no bubble.
- `rst` mid-operation aborts immediately:
  - All outputs return to reset values; no `done` pulse.
  - The aborted operation is lost.

## Configuration
- `MDU_DIV_SIGNED_EN` defined:
  - `sign` is honoured, with magnitude extraction and FIN sign correction as above.
- Not defined:
  - `sign` port remains but is ignored; every operation is unsigned.
  - Negation logic and `neg_q`/`neg_r` registers are not built.
  - Latency is unchanged.

## Structure
- Shared package `mips_pkg`:
  - state enum `div_state_t` (IDLE, CALC, FIN);
  - constant `DIV_ITER` = WIDTH;
  - localparam for counter width ($clog2(WIDTH)).
- One sub-module `div_step`: the combinational single-iteration shift/subtract/select, producing next partial remainder and quotient bit. Instantiated once inside `mdu_divider`.

## Test plan
- Unsigned 100 / 7, start at edge k → `done` at edge k+33 with `quotient`=14, `remainder`=2, `dz`=0; `busy` high for exactly 33 cycles.
- Signed −7 / 2 (0xFFFFFFF9 / 2) → `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF. Without `MDU_DIV_SIGNED_EN` → `quotient`=0x7FFFFFFC, `remainder`=1.
- Signed 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0, `dz`=0.
- 5 / 0 (either mode) → `dz`=1, `quotient`=0xFFFFFFFF, `remainder`=5, same 33-cycle latency.
- `start` pulsed at cycle 10 of an operation with different operands → ignored; original result delivered. Then `start` held in the `done` cycle → second operation accepted with no idle cycle.
- `rst` asserted at cycle 15 of an operation → `busy`, `done`, `dz` go to 0 and `quotient`/`remainder` to 0 immediately; no `done` pulse follows; the next `start` after release works normally.
